// File: rtl/dmem_sram_responder.sv
// M-stage data port to SRAM-like bus responder: one address/data transaction per request,
// stalls the pipeline until done. Optional DMEM_KSEG_MAP_EN folds kseg0/kseg1 to physical.
module dmem_sram_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] data_rdata,
  output logic              d_cache_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e              state_q, state_d;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                start;
  logic                req_wr;
  logic [1:0]          req_size;
  logic [1:0]          req_lo;
  logic [ADDR_W-1:0]   phys_addr;
  logic [ADDR_W-1:0]   req_addr;

`ifdef DMEM_KSEG_MAP_EN
  assign phys_addr = (data_addr[ADDR_W-1 -: 2] == 2'b10) ?
                     {3'b000, data_addr[ADDR_W-4:0]} : data_addr;
`else
  assign phys_addr = data_addr;
`endif

  // Loads and unrecognised enable patterns go out as aligned words.
  always_comb begin
    req_wr   = |data_wen;
    req_size = 2'd2;
    req_lo   = 2'b00;
    case (data_wen)
      4'b0011: begin req_size = 2'd1; req_lo = 2'b00; end
      4'b1100: begin req_size = 2'd1; req_lo = 2'b10; end
      4'b0001: begin req_size = 2'd0; req_lo = 2'b00; end
      4'b0010: begin req_size = 2'd0; req_lo = 2'b01; end
      4'b0100: begin req_size = 2'd0; req_lo = 2'b10; end
      4'b1000: begin req_size = 2'd0; req_lo = 2'b11; end
      default: ;
    endcase
  end

  assign req_addr = {phys_addr[ADDR_W-1:2], req_lo};
  assign start    = (state_q == StIdle) && data_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (data_en) state_d = bus_addr_ok ? StData : StAddr;
      StAddr:  if (bus_addr_ok) state_d = StData;
      StData:  if (bus_data_ok) state_d = StDone;
      StDone:  if (!pipe_stall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The request cycle drives the bus straight from the pipeline so a zero-wait
  // address phase can be accepted before the latches load.
  always_comb begin
    bus_req       = start || (state_q == StAddr);
    d_cache_stall = start || (state_q == StAddr) || (state_q == StData);
    bus_wr        = start ? req_wr     : wr_q;
    bus_size      = start ? req_size   : size_q;
    bus_addr      = start ? req_addr   : addr_q;
    bus_wdata     = start ? data_wdata : wdata_q;
    data_rdata    = rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        wr_q    <= req_wr;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= data_wdata;
      end
      if ((state_q == StData) && bus_data_ok && !wr_q) begin
        rdata_q <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder; each access is driven cycle by cycle with
// hand-derived stall, bus and load-data expectations. Honours DMEM_KSEG_MAP_EN.
module tb_dmem_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        pipe_stall;
  logic [31:0] data_rdata;
  logic        d_cache_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef DMEM_KSEG_MAP_EN
  localparam logic [31:0] LdAddr1 = 32'h0000_0010;
  localparam logic [31:0] LdAddr6 = 32'h0000_0020;
`else
  localparam logic [31:0] LdAddr1 = 32'h8000_0010;
  localparam logic [31:0] LdAddr6 = 32'hA000_0020;
`endif

  dmem_sram_responder #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_en      (data_en),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .pipe_stall   (pipe_stall),
    .data_rdata   (data_rdata),
    .d_cache_stall(d_cache_stall),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    data_en     = 1'b0;
    data_wen    = 4'b0000;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    pipe_stall  = 1'b0;
    #2;
    check("idle_stall", {31'b0, d_cache_stall}, 32'd0);
    check("idle_req", {31'b0, bus_req}, 32'd0);
    tick();
  endtask

  // addr_ok arrives in cycle aw, data_ok in cycle aw+1+dw, then DONE is held by
  // pipe_stall for `hold` cycles. Spurious handshakes are injected outside their phase.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] exp_size,
                        input logic [31:0] exp_addr, input logic [31:0] rd,
                        input logic [31:0] exp_rdata, input int aw, input int dw,
                        input int hold);
    int last;
    int dc;
    int stalls;
    int acc;
    dc     = aw + 1 + dw;
    last   = dc + 1 + hold;
    stalls = 0;
    acc    = 0;
    data_en    = 1'b1;
    data_wen   = wen;
    data_addr  = addr;
    data_wdata = wdata;
    for (int c = 0; c <= last; c++) begin
      bus_addr_ok = (c == aw) || (c > dc);
      bus_data_ok = (c == dc) || (c < aw);
      bus_rdata   = (c == dc) ? rd : 32'h5A5A_5A5A;
      pipe_stall  = (c < last);
      #2;
      check("stall", {31'b0, d_cache_stall}, (c <= dc) ? 32'd1 : 32'd0);
      check("req", {31'b0, bus_req}, (c <= aw) ? 32'd1 : 32'd0);
      if (c <= aw) begin
        check("bus_addr", bus_addr, exp_addr);
        check("bus_size", {30'b0, bus_size}, {30'b0, exp_size});
        check("bus_wr", {31'b0, bus_wr}, (wen != 4'b0000) ? 32'd1 : 32'd0);
        if (wen != 4'b0000) check("bus_wdata", bus_wdata, wdata);
      end
      if (c > dc) check("data_rdata", data_rdata, exp_rdata);
      if (bus_req && bus_addr_ok) acc++;
      if (d_cache_stall) stalls++;
      tick();
    end
    check("stall_total", stalls, dc + 1);
    check("accepts", acc, 32'd1);
  endtask

  initial begin
    rst         = 1'b0;
    data_en     = 1'b0;
    data_wen    = 4'b0000;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    pipe_stall  = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    repeat (2) tick();
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_wr", {31'b0, bus_wr}, 32'd0);
    check("rst_size", {30'b0, bus_size}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    check("rst_stall0", {31'b0, d_cache_stall}, 32'd0);
    data_en = 1'b1;
    #1;
    check("rst_stall1", {31'b0, d_cache_stall}, 32'd1);
    data_en = 1'b0;
    rst     = 1'b1;
    tick();

    // Minimum-latency load word
    access(4'b0000, 32'h8000_0010, 32'h0, 2'd2, LdAddr1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
    idle_cycle();
    // Byte store keeps the earlier load data
    access(4'b0100, 32'h1000_0003, 32'h00AB_0000, 2'd0, 32'h1000_0002, 32'h0,
           32'hDEAD_BEEF, 1, 0, 0);
    idle_cycle();
    // addr_ok in cycle 3, data_ok in cycle 5: six stall cycles
    access(4'b0000, 32'h0000_0106, 32'h0, 2'd2, 32'h0000_0104, 32'h1234_5678,
           32'h1234_5678, 3, 1, 0);
    idle_cycle();
    // DONE held by pipe_stall for 4 cycles
    access(4'b0000, 32'h2000_0008, 32'h0, 2'd2, 32'h2000_0008, 32'hCAFE_F00D,
           32'hCAFE_F00D, 0, 0, 4);
    // Upper-half store followed immediately by a load
    access(4'b1100, 32'h3000_0001, 32'hBEEF_0000, 2'd1, 32'h3000_0002, 32'h0,
           32'hCAFE_F00D, 0, 0, 0);
    access(4'b0000, 32'hA000_0020, 32'h0, 2'd2, LdAddr6, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 0, 0);
    // Full word store and an irregular enable pattern treated as a word
    access(4'b1111, 32'h0000_0042, 32'h1122_3344, 2'd2, 32'h0000_0040, 32'h0,
           32'h0BAD_CAFE, 0, 1, 0);
    access(4'b0101, 32'h0000_0046, 32'h5566_7788, 2'd2, 32'h0000_0044, 32'h0,
           32'h0BAD_CAFE, 1, 1, 1);
    idle_cycle();

    // Reset asserted while in DATA
    data_en     = 1'b1;
    data_wen    = 4'b0000;
    data_addr   = 32'h0000_0200;
    bus_addr_ok = 1'b1;
    #2;
    check("rst_mid_req0", {31'b0, bus_req}, 32'd1);
    tick();
    bus_addr_ok = 1'b0;
    #2;
    check("rst_mid_stall", {31'b0, d_cache_stall}, 32'd1);
    rst     = 1'b0;
    data_en = 1'b0;
    tick();
    check("rst_mid_req", {31'b0, bus_req}, 32'd0);
    check("rst_mid_rdata", data_rdata, 32'd0);
    check("rst_mid_stall0", {31'b0, d_cache_stall}, 32'd0);
    check("rst_mid_addr", bus_addr, 32'd0);
    rst = 1'b1;
    tick();
    access(4'b0000, 32'h0000_0300, 32'h0, 2'd2, 32'h0000_0300, 32'h7777_0001,
           32'h7777_0001, 0, 0, 0);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
